dec_scan_ctrl: RTL and testbench

DEC_SCAN_CTRL -- requirements
Module: dec_scan_ctrl

---
 rtl/dec_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_dec_scan_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dec_scan_ctrl.sv
// Scan controller that steps a 3-bit address for a downstream 3-to-8 decoder,
// holding each address for DWELL enabled cycles. Define SCAN_DOWN_EN to honour dir.
module dec_scan_ctrl #(
  parameter int DWELL = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       hold,
  input  logic       dir,
  input  logic       single,
  output logic [2:0] w,
  output logic       en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [3:0] DWELL_M1 = 4'(DWELL - 1);

  state_t     state_q, state_d;
  logic [2:0] w_q, w_d;
  logic [3:0] cnt_q, cnt_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       single_q, single_d;
  logic [2:0] start_w, first_w, last_w, next_w;

`ifdef SCAN_DOWN_EN
  logic down_q, down_d;

  assign down_d  = (state_q == S_IDLE && start) ? dir : down_q;
  assign start_w = dir ? 3'd7 : 3'd0;
  assign first_w = down_q ? 3'd7 : 3'd0;
  assign last_w  = down_q ? 3'd0 : 3'd7;
  assign next_w  = down_q ? (w_q - 3'd1) : (w_q + 3'd1);

  always_ff @(posedge clk) begin
    if (rst) down_q <= 1'b0;
    else     down_q <= down_d;
  end
`else
  logic unused_dir;

  assign unused_dir = dir;
  assign start_w    = 3'd0;
  assign first_w    = 3'd0;
  assign last_w     = 3'd7;
  assign next_w     = w_q + 3'd1;
`endif

  // cnt_q indexes the enabled cycle currently shown for w_q; an edge without
  // hold consumes it, so a hold never costs or grants an extra dwell cycle.
  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    cnt_d    = cnt_q;
    single_d = single_q;
    en_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          w_d      = start_w;
          cnt_d    = 4'd0;
          single_d = single;
          en_d     = 1'b1;
          busy_d   = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (hold) begin
          busy_d = 1'b1;
        end else begin
          busy_d = 1'b1;
          en_d   = 1'b1;
          if (cnt_q != DWELL_M1) begin
            cnt_d = cnt_q + 4'd1;
          end else begin
            cnt_d = 4'd0;
            if (w_q == last_w) begin
              if (single_q) begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                en_d    = 1'b0;
                done_d  = 1'b1;
              end else begin
                w_d = first_w;
              end
            end else begin
              w_d = next_w;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      w_q      <= 3'd0;
      cnt_q    <= 4'd0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      single_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      single_q <= single_d;
    end
  end

  assign w    = w_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Bench for dec_scan_ctrl: two instances (DWELL=1 and DWELL=3) share stimulus and
// are each compared every cycle against an address-sequence reference model.
module tb_dec_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, stop, hold, dir, single;
  logic [2:0] w0, w1;
  logic en0, en1, busy0, busy1, done0, done1;

  dec_scan_ctrl #(.DWELL(1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold), .dir(dir),
    .single(single), .w(w0), .en(en0), .busy(busy0), .done(done0)
  );

  dec_scan_ctrl #(.DWELL(3)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold), .dir(dir),
    .single(single), .w(w1), .en(en1), .busy(busy1), .done(done1)
  );

  int checks = 0;
  int failures = 0;

  // expected {w, en, busy, done} per instance, one entry per clock
  logic [5:0] exp_q0[$];
  logic [5:0] exp_q1[$];

  // reference model: mode 0 idle, 1 scanning, 2 finishing pass
  int m_mode[2], m_w[2], m_used[2];
  bit m_en[2], m_busy[2], m_done[2], m_down[2], m_one[2];

  function automatic int dwell_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic model_reset(input int i);
    m_mode[i] = 0; m_w[i] = 0; m_used[i] = 0;
    m_en[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_down[i] = 0; m_one[i] = 0;
  endtask

  // m_used counts enabled cycles granted to the current address so far
  task automatic model_step(input int i, input bit r, input bit s, input bit p,
                            input bit h, input bit d, input bit sg);
    int first, last;
    if (r) begin
      model_reset(i);
      return;
    end
    m_done[i] = 0;
    case (m_mode[i])
      0: begin
        m_en[i] = 0; m_busy[i] = 0;
        if (s) begin
`ifdef SCAN_DOWN_EN
          m_down[i] = d;
`else
          m_down[i] = 0;
`endif
          m_one[i] = sg;
          m_mode[i] = 1;
          m_w[i] = m_down[i] ? 7 : 0;
          m_used[i] = 1;
          m_en[i] = 1; m_busy[i] = 1;
        end
      end
      1: begin
        first = m_down[i] ? 7 : 0;
        last  = m_down[i] ? 0 : 7;
        if (p) begin
          m_mode[i] = 0; m_en[i] = 0; m_busy[i] = 0;
        end else if (h) begin
          m_en[i] = 0;
        end else if (m_used[i] < dwell_of(i)) begin
          m_used[i]++; m_en[i] = 1;
        end else if (m_w[i] == last && m_one[i]) begin
          m_mode[i] = 2; m_en[i] = 0; m_busy[i] = 0; m_done[i] = 1;
        end else begin
          m_w[i] = (m_w[i] == last) ? first : (m_down[i] ? m_w[i] - 1 : m_w[i] + 1);
          m_used[i] = 1; m_en[i] = 1;
        end
      end
      default: begin
        m_mode[i] = 0; m_en[i] = 0; m_busy[i] = 0;
      end
    endcase
  endtask

  function automatic logic [5:0] model_out(input int i);
    return {3'(m_w[i]), m_en[i], m_busy[i], m_done[i]};
  endfunction

  task automatic tick(input bit r, input bit s, input bit p, input bit h,
                      input bit d, input bit sg);
    rst = r; start = s; stop = p; hold = h; dir = d; single = sg;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) model_step(i, r, s, p, h, d, sg);
    exp_q0.push_back(model_out(0));
    exp_q1.push_back(model_out(1));
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    logic [5:0] e, g;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      g = {w0, en0, busy0, done0};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL dwell1_out t=%0t got w=%0d en=%b busy=%b done=%b exp w=%0d en=%b busy=%b done=%b",
                 $time, g[5:3], g[2], g[1], g[0], e[5:3], e[2], e[1], e[0]);
      end
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      g = {w1, en1, busy1, done1};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL dwell3_out t=%0t got w=%0d en=%b busy=%b done=%b exp w=%0d en=%b busy=%b done=%b",
                 $time, g[5:3], g[2], g[1], g[0], e[5:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) model_reset(i);
    rst = 1; start = 0; stop = 0; hold = 0; dir = 0; single = 0;
    // reset, then ignored stop/hold in idle
    for (int k = 0; k < 3; k++) tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 1, 0, 0);
    idle_cycles(2);
    // single up pass
    tick(0, 1, 0, 0, 0, 1);
    idle_cycles(30);
    // single pass with dir=1, dir/single toggled mid-run
    tick(0, 1, 0, 0, 1, 1);
    for (int k = 0; k < 30; k++) tick(0, 0, 0, 0, k[0], k[1]);
    // continuous wrap, then stop
    tick(0, 1, 0, 0, 0, 0);
    idle_cycles(28);
    tick(0, 0, 1, 0, 0, 0);
    idle_cycles(2);
    // hold mid-scan, then stop while still holding
    tick(0, 1, 0, 0, 0, 1);
    idle_cycles(3);
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 1, 0, 0);
    idle_cycles(2);
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 1, 1, 0, 0);
    idle_cycles(3);
    // start held through run, then reset mid-run
    for (int k = 0; k < 15; k++) tick(0, 1, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0);
    idle_cycles(2);
    tick(0, 1, 0, 0, 1, 1);
    idle_cycles(30);
    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle_cycles(2);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
